pipelined_dot_engine: RTL and testbench
=======================================

PIPELINED_DOT_ENGINE -- requirements
Module: pipelined_dot_engine

Interface
REQ-001 SHALL have parameter LANES, default 16, meaning parallel multiply lanes (1..256, need not be a power of 2).
REQ-002 SHALL have parameter ELEM_W, default 8, meaning element width in bits.
REQ-003 SHALL have parameter LEN_W, default 11, meaning width of the length field (max 1024 elements at default).
REQ-004 SHALL have parameter ACC_W, default 40, meaning accumulator/result width.
REQ-005 SHALL have port clk  input  1  the single clock; all logic rising-edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-007 SHALL have port start  input  1  operation request, sampled only in IDLE.
REQ-008 SHALL have port len  input  LEN_W  element count, latched on accepted start.
REQ-009 SHALL have port signed_mode  input  1  1 = two's-complement elements, 0 = unsigned, latched on accepted start.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have ports in_valid input 1 / in_ready output 1 for the operand beat handshake.
REQ-012 SHALL have ports in_a, in_b  input  LANES*ELEM_W  one beat of operands, lane k at bits [k*ELEM_W +: ELEM_W].
REQ-013 SHALL have ports res_valid output 1 / res_ready input 1 for the result handshake.
REQ-014 SHALL have port result  output  ACC_W  dot product, sign-extended in signed mode.
REQ-015 SHALL have port overflow  output  1  sticky per operation: accumulator left ACC_W range.
REQ-016 SHALL have port cycle_count  output  16  cycles spent in RUN plus DRAIN, saturating at 16'hFFFF.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DRAIN, DONE; transitions only on clk.
REQ-018 IDLE -> RUN on start with len>0; IDLE -> DONE on start with len=0 (result 0, cycle_count 0).
REQ-019 SHALL compute beats = ceil(len/LANES); in_ready high in RUN only while beats remain.
REQ-020 A beat transfers when in_valid & in_ready; in_valid low inserts a bubble, no accumulation.
REQ-021 On the final beat, lanes with index >= len - (beats-1)*LANES SHALL be forced to product 0.
REQ-022 Pipeline: stage 1 registered lane products (2*ELEM_W), stage 2 registered adder-tree sum, stage 3 accumulate; fixed latency 3 from beat transfer to accumulator update.
REQ-023 RUN -> DRAIN after the last beat transfers; DRAIN lasts exactly 3 cycles, then -> DONE.
REQ-024 DONE: res_valid high, result/overflow/cycle_count held stable until res_valid & res_ready, then -> IDLE.
REQ-025 start SHALL be ignored outside IDLE; in_valid SHALL be ignored outside RUN.
REQ-026 Products and sums SHALL be sign- or zero-extended per latched signed_mode before addition.
REQ-027 overflow SHALL set when any accumulate exceeds ACC_W signed (signed_mode) or unsigned range; result wraps modulo 2^ACC_W.
REQ-028 Accumulator, overflow and cycle_count SHALL clear on accepted start.

Reset
REQ-029 With rst low at a clk edge: state IDLE, pipeline valids cleared, busy 0, in_ready 0, res_valid 0, result 0, overflow 0, cycle_count 0.
REQ-030 Reset mid-operation SHALL abandon the operation; no result is presented afterwards.

Structure
REQ-031 Package dot_pkg SHALL hold the FSM state enum, DRAIN_CYCLES = 3 and the cycle_count width.
REQ-032 Adder tree SHALL be one sub-module dot_adder_tree (parameters LANES, IN_W; one register stage, handles non-power-of-2 LANES).

Verification
REQ-033 Unsigned, len=1024, all elements 255, continuous in_valid -> result 66585600, overflow 0, cycle_count 67.
REQ-034 len=8, A=B=1..8, lanes 8-15 driven with 8'hFF garbage -> result 204, cycle_count 4.
REQ-035 Signed, len=4, A=-128, B=127 -> result -65024 sign-extended to ACC_W, overflow 0.
REQ-036 len=64, in_valid toggled every other cycle -> result identical to continuous run, cycle_count 10.
REQ-037 ACC_W=16, unsigned, len=2, 255x255 -> overflow 1, result 130050 mod 65536 = 64514.
REQ-038 res_ready low 5 cycles in DONE with start pulsed -> outputs stable, start ignored; rst low mid-RUN -> all outputs 0 next cycle, state IDLE.

Source files
------------

// File: rtl/dot_pkg.sv
// Shared types and constants for the pipelined dot-product engine.
package dot_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned DRAIN_CYCLES = 3;
    localparam int unsigned DRAIN_CNT_W  = $clog2(DRAIN_CYCLES);
    localparam int unsigned CYC_W        = 16;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
        return (&v) ? v : v + CYC_W'(1);
    endfunction

endpackage

// File: rtl/dot_adder_tree.sv
// Registered adder tree over LANES inputs; inputs are padded to a power of two with zeros.
module dot_adder_tree #(
    parameter int unsigned LANES = 16,
    parameter int unsigned IN_W  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          signed_mode,
    input  logic [LANES*IN_W-1:0]         in_data,
    output logic [IN_W+$clog2(LANES):0]   sum
);

    localparam int unsigned DEPTH = $clog2(LANES);
    localparam int unsigned PAD   = 1 << DEPTH;
    localparam int unsigned OUT_W = IN_W + DEPTH + 1;

    function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] x, input logic sm);
        return {{(OUT_W-IN_W){sm & x[IN_W-1]}}, x};
    endfunction

    // Level 0 holds extended leaves, each further level halves the node count.
    for (genvar l = 0; l <= DEPTH; l++) begin : g_lvl
        logic [OUT_W-1:0] node [PAD >> l];
        if (l == 0) begin : g_leaf
            for (genvar i = 0; i < PAD; i++) begin : g_in
                if (i < LANES) begin : g_real
                    assign node[i] = extend(in_data[i*IN_W +: IN_W], signed_mode);
                end else begin : g_pad
                    assign node[i] = '0;
                end
            end
        end else begin : g_sum
            for (genvar i = 0; i < (PAD >> l); i++) begin : g_add
                assign node[i] = g_lvl[l-1].node[2*i] + g_lvl[l-1].node[2*i+1];
            end
        end
    end

    // Single pipeline register on the tree root.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sum <= '0;
        end else begin
            sum <= g_lvl[DEPTH].node[0];
        end
    end

endmodule

// File: rtl/pipelined_dot_engine.sv
// Streaming dot-product engine: multiply stage, adder-tree stage, accumulate stage.
module pipelined_dot_engine
    import dot_pkg::*;
#(
    parameter int unsigned LANES  = 16,
    parameter int unsigned ELEM_W = 8,
    parameter int unsigned LEN_W  = 11,
    parameter int unsigned ACC_W  = 40
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [LEN_W-1:0]          len,
    input  logic                      signed_mode,
    output logic                      busy,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*ELEM_W-1:0]   in_a,
    input  logic [LANES*ELEM_W-1:0]   in_b,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [ACC_W-1:0]          result,
    output logic                      overflow,
    output logic [CYC_W-1:0]          cycle_count
);

    localparam int unsigned PROD_W  = 2 * ELEM_W;
    localparam int unsigned SUM_W   = PROD_W + $clog2(LANES) + 1;
    localparam int unsigned EXT_W   = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 2;
    localparam int unsigned LANE_CW = $clog2(LANES + 1);

    state_t                   state, state_d;
    logic [LEN_W-1:0]         beats_left, beats_d, beats_start;
    logic [DRAIN_CNT_W-1:0]   drain_cnt, drain_d;
    logic [LANE_CW-1:0]       last_lanes, last_start;
    logic [31:0]              len_m1;
    logic                     mode_q, accept, xfer, final_beat;
    logic                     p1_valid, p2_valid;
    logic [LANES*PROD_W-1:0]  prod_c, prod_q;
    logic [SUM_W-1:0]         sum_q;
    logic [EXT_W-1:0]         acc_ext, sum_ext, acc_sum;
    logic                     ovf_now;

    // Beat count and live lanes of the final beat, derived from the requested length.
    always_comb begin
        len_m1      = 32'(len) - 32'd1;
        beats_start = LEN_W'(len_m1 / LANES + 32'd1);
        last_start  = LANE_CW'(len_m1 % LANES + 32'd1);
    end

    // Next-state logic and beat/drain bookkeeping.
    always_comb begin
        state_d    = state;
        beats_d    = beats_left;
        drain_d    = drain_cnt;
        accept     = (state == IDLE) && start;
        final_beat = (beats_left == LEN_W'(1));
        xfer       = (state == RUN) && (beats_left != '0) && in_valid;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                        beats_d = beats_start;
                    end
                end
            end
            RUN: begin
                if (xfer) begin
                    beats_d = beats_left - LEN_W'(1);
                    if (final_beat) begin
                        state_d = DRAIN;
                        drain_d = '0;
                    end
                end
            end
            DRAIN: begin
                drain_d = drain_cnt + DRAIN_CNT_W'(1);
                if (drain_cnt == DRAIN_CNT_W'(DRAIN_CYCLES - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Lane products; lanes past the requested length on the final beat contribute zero.
    always_comb begin
        logic signed [ELEM_W:0]   sa, sb;
        logic signed [PROD_W-1:0] pf;
        prod_c = '0;
        for (int k = 0; k < LANES; k++) begin
            sa = $signed({mode_q & in_a[k*ELEM_W + ELEM_W - 1], in_a[k*ELEM_W +: ELEM_W]});
            sb = $signed({mode_q & in_b[k*ELEM_W + ELEM_W - 1], in_b[k*ELEM_W +: ELEM_W]});
            pf = PROD_W'(sa) * PROD_W'(sb);
            if (final_beat && (LANE_CW'(k) >= last_lanes)) begin
                pf = '0;
            end
            prod_c[k*PROD_W +: PROD_W] = pf;
        end
    end

    // Accumulate in a widened domain so range escape is visible in the upper bits.
    always_comb begin
        acc_ext = {{(EXT_W-ACC_W){mode_q & result[ACC_W-1]}}, result};
        sum_ext = {{(EXT_W-SUM_W){mode_q & sum_q[SUM_W-1]}}, sum_q};
        acc_sum = acc_ext + sum_ext;
        if (mode_q) begin
            ovf_now = !((&acc_sum[EXT_W-1:ACC_W-1]) || !(|acc_sum[EXT_W-1:ACC_W-1]));
        end else begin
            ovf_now = |acc_sum[EXT_W-1:ACC_W];
        end
    end

    dot_adder_tree #(
        .LANES (LANES),
        .IN_W  (PROD_W)
    ) u_tree (
        .clk         (clk),
        .rst         (rst),
        .signed_mode (mode_q),
        .in_data     (prod_q),
        .sum         (sum_q)
    );

    // State register and registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            beats_left <= '0;
            drain_cnt  <= '0;
            busy       <= 1'b0;
            in_ready   <= 1'b0;
            res_valid  <= 1'b0;
        end else begin
            state      <= state_d;
            beats_left <= beats_d;
            drain_cnt  <= drain_d;
            busy       <= (state_d != IDLE);
            in_ready   <= (state_d == RUN) && (beats_d != '0);
            res_valid  <= (state_d == DONE);
        end
    end

    // Datapath: product stage, valid pipeline, accumulator and cycle counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_q      <= 1'b0;
            last_lanes  <= '0;
            p1_valid    <= 1'b0;
            p2_valid    <= 1'b0;
            prod_q      <= '0;
            result      <= '0;
            overflow    <= 1'b0;
            cycle_count <= '0;
        end else begin
            p1_valid <= xfer;
            p2_valid <= p1_valid;
            if (xfer) begin
                prod_q <= prod_c;
            end
            if (accept) begin
                mode_q      <= signed_mode;
                last_lanes  <= last_start;
                result      <= '0;
                overflow    <= 1'b0;
                cycle_count <= '0;
            end else begin
                if (p2_valid) begin
                    result   <= acc_sum[ACC_W-1:0];
                    overflow <= overflow | ovf_now;
                end
                if ((state == RUN) || (state == DRAIN)) begin
                    cycle_count <= sat_inc(cycle_count);
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_dot_engine.sv
// Scoreboard bench for pipelined_dot_engine with directed vectors.
module tb_pipelined_dot_engine;

    localparam int unsigned LANES  = 16;
    localparam int unsigned ELEM_W = 8;
    localparam int unsigned LEN_W  = 11;
    localparam int unsigned ACC_W  = 40;
    localparam int unsigned ACC16  = 16;

    typedef struct packed {
        logic [39:0] res;
        logic        ovf;
        logic [15:0] cyc;
        logic [7:0]  id;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst;
    logic                     start, signed_mode, in_valid, res_ready;
    logic [LEN_W-1:0]         len;
    logic [LANES*ELEM_W-1:0]  in_a, in_b;
    logic                     busy, in_ready, res_valid, overflow;
    logic [ACC_W-1:0]         result;
    logic [15:0]              cycle_count;

    logic                     start16, busy16, in_ready16, res_valid16, overflow16;
    logic [ACC16-1:0]         result16;
    logic [15:0]              cycle_count16;
    logic [LANES*ELEM_W-1:0]  ones;

    exp_t exp_q[$];
    exp_t exp16_q[$];
    int   checks = 0;
    int   errors = 0;

    pipelined_dot_engine #(.LANES(LANES), .ELEM_W(ELEM_W), .LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .signed_mode(signed_mode),
        .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .res_valid(res_valid), .res_ready(res_ready), .result(result),
        .overflow(overflow), .cycle_count(cycle_count)
    );

    pipelined_dot_engine #(.LANES(LANES), .ELEM_W(ELEM_W), .LEN_W(LEN_W), .ACC_W(ACC16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .len(LEN_W'(2)), .signed_mode(1'b0),
        .busy(busy16), .in_valid(1'b1), .in_ready(in_ready16), .in_a(ones), .in_b(ones),
        .res_valid(res_valid16), .res_ready(1'b1), .result(result16),
        .overflow(overflow16), .cycle_count(cycle_count16)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Monitor: compare the head of the scoreboard every cycle a result is shown.
    always @(negedge clk) begin
        exp_t e;
        if (res_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_res_valid", 64'(res_valid), 64'd0);
            end else begin
                e = exp_q[0];
                chk($sformatf("op%0d_result", e.id), 64'(result), 64'(e.res));
                chk($sformatf("op%0d_overflow", e.id), 64'(overflow), 64'(e.ovf));
                chk($sformatf("op%0d_cycle_count", e.id), 64'(cycle_count), 64'(e.cyc));
                if (res_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Monitor for the narrow-accumulator instance.
    always @(negedge clk) begin
        exp_t e;
        if (res_valid16) begin
            if (exp16_q.size() == 0) begin
                chk("unexpected_res_valid16", 64'(res_valid16), 64'd0);
            end else begin
                e = exp16_q.pop_front();
                chk("acc16_result", 64'(result16), 64'(e.res));
                chk("acc16_overflow", 64'(overflow16), 64'(e.ovf));
                chk("acc16_cycle_count", 64'(cycle_count16), 64'(e.cyc));
            end
        end
    end

    // Element generator: elements past the length are 8'hFF garbage.
    function automatic logic [7:0] elem(input int pat, input int idx, input int n, input bit is_b);
        logic [7:0] v;
        if (idx >= n) return 8'hFF;
        case (pat)
            0:       v = 8'hFF;
            1:       v = 8'(idx + 1);
            2:       v = is_b ? 8'h7F : 8'h80;
            3:       v = is_b ? 8'd3 : 8'(idx + 1);
            default: v = is_b ? 8'hFF : 8'(idx + 1);
        endcase
        return v;
    endfunction

    task automatic set_beat(input int pat, input int b, input int n);
        for (int k = 0; k < int'(LANES); k++) begin
            in_a[k*ELEM_W +: ELEM_W] = elem(pat, b*int'(LANES) + k, n, 1'b0);
            in_b[k*ELEM_W +: ELEM_W] = elem(pat, b*int'(LANES) + k, n, 1'b1);
        end
    endtask

    task automatic wait_not_busy(input int id);
        int g = 0;
        while (busy && g < 2000) begin
            @(posedge clk); #1;
            g++;
        end
        if (busy) chk($sformatf("op%0d_completion_timeout", id), 64'(busy), 64'd0);
    endtask

    task automatic do_op(input int id, input int n, input bit sm, input int pat, input bit gap,
                         input bit hold, input logic [39:0] er, input logic eo, input logic [15:0] ec);
        exp_t e;
        int   nb, g;
        e.res = er; e.ovf = eo; e.cyc = ec; e.id = 8'(id);
        exp_q.push_back(e);
        res_ready   = !hold;
        start       = 1'b1;
        len         = LEN_W'(n);
        signed_mode = sm;
        @(posedge clk); #1;
        start = 1'b0;
        nb = (n + int'(LANES) - 1) / int'(LANES);
        for (int b = 0; b < nb; b++) begin
            if (gap && b > 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            set_beat(pat, b, n);
            in_valid = 1'b1;
            g = 0;
            while (!in_ready && g < 100) begin
                @(posedge clk); #1;
                g++;
            end
            if (!in_ready) chk($sformatf("op%0d_in_ready_timeout", id), 64'(in_ready), 64'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        set_beat(0, 0, 0);
        if (hold) begin
            g = 0;
            while (!res_valid && g < 100) begin
                @(posedge clk); #1;
                g++;
            end
            if (!res_valid) chk($sformatf("op%0d_res_valid_timeout", id), 64'(res_valid), 64'd1);
            for (int c = 0; c < 5; c++) begin
                start = (c == 1);
                len   = LEN_W'(5);
                @(posedge clk); #1;
            end
            start     = 1'b0;
            res_ready = 1'b1;
            @(posedge clk); #1;
            chk("hold_busy_after_ack", 64'(busy), 64'd0);
        end
        wait_not_busy(id);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; start = 1'b0; start16 = 1'b0; signed_mode = 1'b0; in_valid = 1'b0;
        res_ready = 1'b1; len = '0; in_a = '0; in_b = '0; ones = '1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        chk("reset_res_valid", 64'(res_valid), 64'd0);
        chk("reset_result", 64'(result), 64'd0);
        chk("reset_overflow", 64'(overflow), 64'd0);
        chk("reset_cycle_count", 64'(cycle_count), 64'd0);
        chk("reset_busy16", 64'(busy16), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Narrow accumulator: 2 x 255*255 = 130050 wraps to 64514.
        begin
            exp_t e16;
            int g = 0;
            e16.res = 40'd64514; e16.ovf = 1'b1; e16.cyc = 16'd4; e16.id = 8'd100;
            exp16_q.push_back(e16);
            start16 = 1'b1;
            @(posedge clk); #1;
            start16 = 1'b0;
            while (busy16 && g < 100) begin
                @(posedge clk); #1;
                g++;
            end
            if (busy16) chk("acc16_timeout", 64'(busy16), 64'd0);
        end

        do_op(1, 1024, 1'b0, 0, 1'b0, 1'b0, 40'd66585600, 1'b0, 16'd67);
        do_op(2, 8,    1'b0, 1, 1'b0, 1'b0, 40'd204,      1'b0, 16'd4);
        do_op(3, 4,    1'b1, 2, 1'b0, 1'b0, -40'sd65024,  1'b0, 16'd4);
        do_op(4, 64,   1'b0, 3, 1'b0, 1'b0, 40'd6240,     1'b0, 16'd7);
        do_op(5, 64,   1'b0, 3, 1'b1, 1'b0, 40'd6240,     1'b0, 16'd10);
        do_op(6, 0,    1'b0, 0, 1'b0, 1'b0, 40'd0,        1'b0, 16'd0);
        do_op(7, 20,   1'b1, 4, 1'b0, 1'b0, -40'sd210,    1'b0, 16'd5);
        do_op(8, 8,    1'b0, 1, 1'b0, 1'b1, 40'd204,      1'b0, 16'd4);
        @(posedge clk); #1;
        chk("start_ignored_in_done", 64'(busy), 64'd0);

        // Abandon an operation part-way through RUN.
        start = 1'b1; len = LEN_W'(1024); signed_mode = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        set_beat(0, 0, 1024);
        in_valid = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrun_rst_busy", 64'(busy), 64'd0);
        chk("midrun_rst_in_ready", 64'(in_ready), 64'd0);
        chk("midrun_rst_res_valid", 64'(res_valid), 64'd0);
        chk("midrun_rst_result", 64'(result), 64'd0);
        chk("midrun_rst_overflow", 64'(overflow), 64'd0);
        chk("midrun_rst_cycle_count", 64'(cycle_count), 64'd0);
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("after_rst_busy", 64'(busy), 64'd0);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        chk("scoreboard16_empty", 64'(exp16_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
